quant_packer: RTL and testbench
===============================

Name: quant_packer

Overview:
- Downstream of the quantizer; consumes its int8 output stream (data_out/valid_out).
- Packs LANES consecutive bytes into one wide word, little-endian, and buffers words in a small FIFO.
- Presents words to the memory writer over a valid/ready stream with keep mask and frame-last flag.
- The quantizer has no backpressure, so the FIFO absorbs write stalls and overflow is flagged, never blocks input.

Parameters:
LANES, 8, bytes per output word (power of two, 2..16)
FIFO_DEPTH, 16, words of output buffering (power of two, >=2)
CNT_W, 20, width of frame byte counter

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
data_in  in  8  int8 byte from quantizer
valid_in  in  1  data_in valid this cycle
start  in  1  single-cycle pulse; begins a frame of frame_len bytes
frame_len  in  CNT_W  bytes in frame; sampled when start accepted
m_data  out  8*LANES  packed word; lane i at bits [8i+7:8i]
m_keep  out  LANES  byte-valid mask for m_data
m_last  out  1  word is final word of frame
m_valid  out  1  output word available
m_ready  in  1  downstream accepts word
busy  out  1  high in PACK or FLUSH
overflow  out  1  sticky; a word was dropped because FIFO full

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE, lane/byte counters 0, FIFO empty, word register 0; m_valid=0, m_data=0, m_keep=0, m_last=0, busy=0, overflow=0. Reset mid-frame discards all partial and buffered data.
- States:
  - IDLE: valid_in ignored. start && frame_len!=0 -> load remaining=frame_len, clear overflow, lane=0 -> PACK. start with frame_len==0 ignored.
  - PACK: each valid_in byte is written to lane[lane_cnt], with keep bit set; lane_cnt++, remaining--.
    - Word completes when lane_cnt==LANES-1 or remaining==1. At that edge the word, keep, and last=(remaining==1) go to the push stage; lane_cnt resets to 0 and the word register clears.
    - Unused lanes of a partial final word are zero with keep=0. After the last byte -> FLUSH.
  - FLUSH: valid_in ignored. When FIFO empty and no push pending -> IDLE.
  - start while busy is ignored.
- Push stage: one register between packer and FIFO. A word completing at edge k is written to the FIFO at edge k+1.
- FIFO is show-ahead: m_valid rises in the cycle after edge k+1. Minimum valid_in-to-m_valid latency is 2 cycles.
- If the FIFO is full at the push edge and no pop occurs that edge, the word is dropped and overflow is set. overflow stays high until the next accepted start or reset.
- Simultaneous push and pop with FIFO full: both succeed, no drop.
- Output handshake: transfer on m_valid && m_ready. m_data, m_keep, and m_last hold stable while m_valid && !m_ready. m_valid is never withdrawn without a transfer.
- Input is sustained 1 byte/cycle; output is 1 word/cycle. Throughput is never input-limited by the packer.
- Counters wrap-free: remaining stops at 0. frame_len up to 2^CNT_W-1 is supported.

Optional Feature:
- Macro QPACK_STATS_EN.
- Defined: extra output port drop_count [15:0]. Increments on each dropped word, saturates at 16'hFFFF, clears on accepted start and on reset.
- Not defined: port and counter absent; overflow still present.

Test Plan:
- start, frame_len=16, 16 bytes 0x01..0x10 on back-to-back cycles, m_ready=1 -> two words 0x0807060504030201 and 0x100F0E0D0C0B0A09. keep=0xFF both, m_last only on the second. First m_valid 2 cycles after byte 8 sampled. busy falls after the second transfer.
- frame_len=11, bytes 0xA0..0xAA -> word0 keep=0xFF, last=0. Word1 = 0x0000000000AAA9A8, keep=0x07, last=1.
- m_ready=0 for 20 cycles during a 24-byte frame -> 3 words queued, no overflow. Data held stable while stalled. Releasing m_ready drains 3 words in 3 consecutive cycles.
- FIFO_DEPTH=16, m_ready=0, frame_len=136 -> 16 words stored and word 17 dropped. overflow=1 (drop_count=1 with QPACK_STATS_EN). Next start clears both.
- start with frame_len=0 -> stays IDLE, busy=0. start asserted mid-frame -> ignored, frame completes normally. valid_in bytes in IDLE produce no output.
- rst_n pulled low with 5 bytes packed and 2 words queued -> all outputs 0 immediately. After release, a new 8-byte frame produces exactly one word with correct data.

Source files
------------

// File: rtl/quant_packer.sv
// rtl/quant_packer.sv - packs int8 quantizer bytes into LANES-wide words behind a show-ahead FIFO
// Optional drop counter enabled by defining QPACK_STATS_EN.
module quant_packer #(
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           data_in,
    input  logic                 valid_in,
    input  logic                 start,
    input  logic [CNT_W-1:0]     frame_len,
    output logic [8*LANES-1:0]   m_data,
    output logic [LANES-1:0]     m_keep,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 overflow
`ifdef QPACK_STATS_EN
    ,
    output logic [15:0]          drop_count
`endif
);
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_FLUSH} state_t;

    state_t               r_state, w_state_next;
    logic [LANE_W-1:0]    r_lane;
    logic [CNT_W-1:0]     r_remaining;
    logic [8*LANES-1:0]   r_word, w_word_cur;
    logic [LANES-1:0]     r_keep, w_keep_cur;
    logic                 w_start_acc, w_byte_acc, w_word_done;

    logic                 r_push_vld, r_push_last;
    logic [8*LANES-1:0]   r_push_data;
    logic [LANES-1:0]     r_push_keep;

    logic [8*LANES-1:0]   r_mem_data [FIFO_DEPTH];
    logic [LANES-1:0]     r_mem_keep [FIFO_DEPTH];
    logic                 r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 w_empty, w_full, w_pop, w_push_ok, w_drop;

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_byte_acc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (frame_len != '0)) begin
                    w_start_acc  = 1'b1;
                    w_state_next = S_PACK;
                end
            end
            S_PACK: begin
                if (valid_in) begin
                    w_byte_acc = 1'b1;
                    if (r_remaining == CNT_W'(1))
                        w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_empty && !r_push_vld)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_word_cur = r_word;
        w_keep_cur = r_keep;
        w_word_cur[{r_lane, 3'b000} +: 8] = data_in;
        w_keep_cur[r_lane] = 1'b1;
        w_word_done = w_byte_acc &&
                      ((r_lane == LANE_W'(LANES-1)) || (r_remaining == CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_remaining <= '0;
            r_word      <= '0;
            r_keep      <= '0;
            r_push_vld  <= 1'b0;
            r_push_data <= '0;
            r_push_keep <= '0;
            r_push_last <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_push_vld <= w_word_done;
            if (w_word_done) begin
                r_push_data <= w_word_cur;
                r_push_keep <= w_keep_cur;
                r_push_last <= (r_remaining == CNT_W'(1));
            end
            if (w_start_acc) begin
                r_remaining <= frame_len;
                r_lane      <= '0;
                r_word      <= '0;
                r_keep      <= '0;
            end else if (w_byte_acc) begin
                if (r_remaining != '0)
                    r_remaining <= r_remaining - CNT_W'(1);
                if (w_word_done) begin
                    r_lane <= '0;
                    r_word <= '0;
                    r_keep <= '0;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                    r_word <= w_word_cur;
                    r_keep <= w_keep_cur;
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop     = m_valid && m_ready;
    assign w_push_ok = r_push_vld && (!w_full || w_pop);
    assign w_drop    = r_push_vld && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_data[r_wr_ptr] <= r_push_data;
            r_mem_keep[r_wr_ptr] <= r_push_keep;
            r_mem_last[r_wr_ptr] <= r_push_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overflow <= 1'b0;
        else if (w_start_acc) overflow <= 1'b0;
        else if (w_drop)      overflow <= 1'b1;
    end

`ifdef QPACK_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              drop_count <= '0;
        else if (w_start_acc)                    drop_count <= '0;
        else if (w_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
`endif

    assign m_valid = !w_empty;
    assign m_data  = m_valid ? r_mem_data[r_rd_ptr] : '0;
    assign m_keep  = m_valid ? r_mem_keep[r_rd_ptr] : '0;
    assign m_last  = m_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_quant_packer.sv
// tb/tb_quant_packer.sv - scoreboard bench for quant_packer
module tb_quant_packer;
    localparam int LANES = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        data_in;
    logic              valid_in;
    logic              start;
    logic [CNT_W-1:0]  frame_len;
    logic [63:0]       m_data;
    logic [7:0]        m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              overflow;
`ifdef QPACK_STATS_EN
    logic [15:0]       drop_count;
`endif

    always #5 clk = ~clk;

    quant_packer #(.LANES(LANES), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .start(start), .frame_len(frame_len), .m_data(m_data), .m_keep(m_keep),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .overflow(overflow)
`ifdef QPACK_STATS_EN
        , .drop_count(drop_count)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    logic        stall_prev = 1'b0;
    logic [63:0] hold_d;
    logic [7:0]  hold_k;
    logic        hold_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_chk++;
                if (!m_valid || m_data !== hold_d || m_keep !== hold_k || m_last !== hold_l) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b %h/%h/%b expected %h/%h/%b",
                             m_valid, m_data, m_keep, m_last, hold_d, hold_k, hold_l);
                end
            end
            if (m_valid && m_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got %h/%h/%b expected none", m_data, m_keep, m_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_keep !== e.k || m_last !== e.l) begin
                        n_err++;
                        $display("FAIL word: got %h/%h/%b expected %h/%h/%b",
                                 m_data, m_keep, m_last, e.d, e.k, e.l);
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            hold_d = m_data;
            hold_k = m_keep;
            hold_l = m_last;
        end
    end

    task automatic send_frame(input int len, input int nsend, input logic [7:0] base,
                              input bit model, input int keep_words,
                              input bit mid_start, input bit lat_chk);
        int          lane = 0;
        int          nw = 0;
        logic [63:0] w = '0;
        logic [7:0]  k = '0;
        logic [7:0]  b;
        @(posedge clk); #1;
        start = 1'b1;
        frame_len = len[CNT_W-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            b = base + 8'(i);
            valid_in = 1'b1;
            data_in = b;
            if (mid_start && i == 3) begin
                start = 1'b1;
                frame_len = 20'd3;
            end else begin
                start = 1'b0;
            end
            if (model) begin
                w[8*lane +: 8] = b;
                k[lane] = 1'b1;
                if (lane == LANES-1 || i == len-1) begin
                    if (nw < keep_words) exp_q.push_back({w, k, (i == len-1)});
                    nw++;
                    lane = 0;
                    w = '0;
                    k = '0;
                end else begin
                    lane++;
                end
            end
            @(posedge clk); #1;
            if (lat_chk && i == 7) check("lat_not_early", m_valid, 1'b0);
            if (lat_chk && i == 8) check("lat_2cyc", m_valid, 1'b1);
        end
        valid_in = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; data_in = '0; valid_in = 1'b0; start = 1'b0;
        frame_len = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", m_valid, 1'b0);
        check("rst_data", m_data, 64'h0);
        check("rst_keep", m_keep, 8'h0);
        check("rst_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // 16 full bytes -> two full words, last on the second
        exp_q.push_back({64'h0807060504030201, 8'hFF, 1'b0});
        exp_q.push_back({64'h100F0E0D0C0B0A09, 8'hFF, 1'b1});
        send_frame(16, 16, 8'h01, 1'b0, 0, 1'b0, 1'b1);
        check("t1_busy_after_bytes", busy, 1'b1);
        wait_idle("t1_idle");
        check("t1_drained", exp_q.size(), 0);
        check("t1_valid_low", m_valid, 1'b0);

        // partial final word
        exp_q.push_back({64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b0});
        exp_q.push_back({64'h0000000000AAA9A8, 8'h07, 1'b1});
        send_frame(11, 11, 8'hA0, 1'b0, 0, 1'b0, 1'b0);
        wait_idle("t2_idle");
        check("t2_drained", exp_q.size(), 0);

        // stall: 3 words queued, then drained back to back
        m_ready = 1'b0;
        send_frame(24, 24, 8'h30, 1'b1, 99, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("t3_valid", m_valid, 1'b1);
        check("t3_head", m_data, 64'h3736353433323130);
        check("t3_no_ovf", overflow, 1'b0);
        check("t3_busy", busy, 1'b1);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t3_drain_valid", m_valid, 1'b1);
            @(posedge clk); #1;
        end
        check("t3_empty", m_valid, 1'b0);
        wait_idle("t3_idle");

        // overflow: 17 words into 16-deep FIFO
        m_ready = 1'b0;
        send_frame(136, 136, 8'h00, 1'b1, 16, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("t4_ovf", overflow, 1'b1);
`ifdef QPACK_STATS_EN
        check("t4_drop_cnt", drop_count, 16'd1);
`endif
        m_ready = 1'b1;
        wait_idle("t4_idle");
        check("t4_drained", exp_q.size(), 0);
        check("t4_ovf_sticky", overflow, 1'b1);

        // zero-length start ignored
        @(posedge clk); #1;
        start = 1'b1; frame_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_len0_busy", busy, 1'b0);
        check("t5_len0_ovf_kept", overflow, 1'b1);

        // bytes in IDLE produce nothing
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; data_in = 8'(8'hE0 + i);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("t5_idle_no_out", m_valid, 1'b0);

        // start mid-frame ignored; accepted start clears overflow
        send_frame(8, 8, 8'h50, 1'b1, 99, 1'b1, 1'b0);
        check("t5_ovf_cleared", overflow, 1'b0);
`ifdef QPACK_STATS_EN
        check("t5_drop_cleared", drop_count, 16'd0);
`endif
        wait_idle("t5_idle");
        check("t5_drained", exp_q.size(), 0);

        // reset with 2 words queued and 5 bytes packed
        m_ready = 1'b0;
        send_frame(24, 21, 8'h60, 1'b1, 99, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t6_pre_valid", m_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", m_valid, 1'b0);
        check("t6_rst_data", m_data, 64'h0);
        check("t6_rst_keep", m_keep, 8'h0);
        check("t6_rst_last", m_last, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        send_frame(8, 8, 8'hC0, 1'b1, 99, 1'b0, 1'b0);
        wait_idle("t6_idle");
        check("t6_drained", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
